// File: rtl/riscv_dcache_pkg.sv
// Shared types and defaults for the burst data-cache controller.
// Optional build macro used by the controller: DCACHE_PERF_CNT_EN.
package riscv_dcache_pkg;

    localparam int DEF_LINE_BEATS = 4;
    localparam int DEF_NUM_SETS   = 64;
    localparam int DEF_CNT_W      = 32;

    typedef enum logic [3:0] {
        IDLE,
        COMPARE,
        WB,
        ALLOC,
        COMPARE2,
        WB2,
        ALLOC2,
        ACCESS,
        FLUSH_CHK,
        FLUSH_WB
    } state_t;

    // Index width for a counter of the given depth; never narrower than one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/riscv_dcache_beat_cnt.sv
// Wrap-around index counter with enable and a last-position flag.
// Used for the beat within a line burst and for the flush set scanner.
module riscv_dcache_beat_cnt
    import riscv_dcache_pkg::*;
#(
    parameter int  DEPTH = DEF_LINE_BEATS,
    localparam int W     = idx_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         last
);

    assign last = (idx == W'(DEPTH - 1));

    // Advance on enable and wrap to zero after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (en) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_dcache_burst_fsm.sv
// Data-cache controller: line fills and writebacks as LINE_BEATS-beat bursts,
// misaligned accesses split over two lines, and a full-cache dirty flush.
// Outputs are decoded from the current state and the same-cycle memory
// handshake, since array writes must coincide with the accepted beat.
// Optional build macro: DCACHE_PERF_CNT_EN adds hit/miss/writeback counters.
module riscv_dcache_burst_fsm
    import riscv_dcache_pkg::*;
#(
    parameter int LINE_BEATS = DEF_LINE_BEATS,
    parameter int NUM_SETS   = DEF_NUM_SETS
`ifdef DCACHE_PERF_CNT_EN
    ,
    parameter int CNT_W      = DEF_CNT_W
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_rden,
    input  logic                          cpu_wren,
    input  logic                          misaligned,
    input  logic                          hit,
    input  logic                          hit_misaligned,
    input  logic                          dirty,
    input  logic                          dirty_misaligned,
    input  logic                          mem_ready,
    input  logic                          flush_req,
    output logic                          cache_rden,
    output logic                          cache_wren,
    output logic                          cache_insel,
    output logic                          addr_insel,
    output logic                          tag_sel,
    output logic                          mem_rden,
    output logic                          mem_wren,
    output logic [idx_w(LINE_BEATS)-1:0]  beat_idx,
    output logic                          set_dirty,
    output logic                          set_valid,
    output logic                          replace_tag,
    output logic                          clr_dirty,
    output logic                          flush_sel,
    output logic [idx_w(NUM_SETS)-1:0]    flush_idx,
    output logic                          flush_done,
    output logic                          stall,
    output logic                          cpu_rden_reg,
    output logic                          cpu_wren_reg
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt,
    output logic [CNT_W-1:0]              wb_cnt
`endif
);

    state_t state, next_state;
    logic   beat_en, beat_last;
    logic   flush_en, flush_last;
    logic   second, line_hit, line_dirty;

    riscv_dcache_beat_cnt #(.DEPTH(LINE_BEATS)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (beat_en),
        .idx  (beat_idx),
        .last (beat_last)
    );

    riscv_dcache_beat_cnt #(.DEPTH(NUM_SETS)) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (flush_en),
        .idx  (flush_idx),
        .last (flush_last)
    );

    // Next-state and output decode from the current state and live inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state  = state;
        cache_rden  = 1'b0;
        cache_wren  = 1'b0;
        cache_insel = 1'b0;
        addr_insel  = 1'b0;
        tag_sel     = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        set_dirty   = 1'b0;
        set_valid   = 1'b0;
        replace_tag = 1'b0;
        clr_dirty   = 1'b0;
        flush_sel   = 1'b0;
        flush_done  = 1'b0;
        stall       = 1'b1;
        beat_en     = 1'b0;
        flush_en    = 1'b0;
        second      = (state == COMPARE2);
        line_hit    = second ? hit_misaligned : hit;
        line_dirty  = second ? dirty_misaligned : dirty;

        case (state)
            IDLE: begin
                stall = 1'b0;
                if (flush_req) begin
                    next_state = FLUSH_CHK;
                end else if (cpu_rden || cpu_wren) begin
                    next_state = COMPARE;
                end
            end
            COMPARE, COMPARE2: begin
                addr_insel = second;
                if (line_hit && (second || !misaligned)) begin
                    stall       = 1'b0;
                    cache_rden  = cpu_rden_reg;
                    cache_wren  = cpu_wren_reg;
                    set_dirty   = 1'b1;
                    set_valid   = 1'b1;
                    replace_tag = cpu_wren_reg;
                    next_state  = (cpu_rden || cpu_wren) ? COMPARE : IDLE;
                end else if (line_hit) begin
                    next_state = COMPARE2;
                end else if (line_dirty) begin
                    cache_rden = 1'b1;
                    tag_sel    = 1'b1;
                    next_state = second ? WB2 : WB;
                end else begin
                    mem_rden   = 1'b1;
                    next_state = second ? ALLOC2 : ALLOC;
                end
            end
            WB, WB2, FLUSH_WB: begin
                mem_wren   = 1'b1;
                cache_rden = 1'b1;
                tag_sel    = 1'b1;
                addr_insel = (state == WB2);
                flush_sel  = (state == FLUSH_WB);
                beat_en    = mem_ready;
                if (mem_ready && beat_last) begin
                    if (state == WB) begin
                        next_state = ALLOC;
                    end else if (state == WB2) begin
                        next_state = ALLOC2;
                    end else begin
                        clr_dirty = 1'b1;
                        flush_en  = 1'b1;
                        if (flush_last) begin
                            flush_done = 1'b1;
                            next_state = IDLE;
                        end else begin
                            next_state = FLUSH_CHK;
                        end
                    end
                end
            end
            ALLOC, ALLOC2: begin
                mem_rden    = 1'b1;
                cache_insel = 1'b1;
                cache_wren  = mem_ready;
                addr_insel  = (state == ALLOC2);
                beat_en     = mem_ready;
                if (mem_ready && beat_last) begin
                    replace_tag = 1'b1;
                    set_valid   = 1'b1;
                    set_dirty   = cpu_wren_reg;
                    next_state  = ((state == ALLOC) && misaligned) ? COMPARE2 : ACCESS;
                end
            end
            ACCESS: begin
                stall      = 1'b0;
                cache_rden = cpu_rden_reg;
                cache_wren = cpu_wren_reg;
                next_state = (cpu_rden || cpu_wren) ? COMPARE : IDLE;
            end
            FLUSH_CHK: begin
                flush_sel = 1'b1;
                if (dirty) begin
                    next_state = FLUSH_WB;
                end else begin
                    flush_en = 1'b1;
                    if (flush_last) begin
                        flush_done = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and pipeline request capture while the pipe is moving.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state        <= IDLE;
            cpu_rden_reg <= 1'b0;
            cpu_wren_reg <= 1'b0;
        end else begin
            state <= next_state;
            if (!stall) begin
                cpu_rden_reg <= cpu_rden;
                cpu_wren_reg <= cpu_wren;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic hit_evt, miss_evt, wb_evt;

    assign hit_evt  = ((state == COMPARE) || (state == COMPARE2)) && !stall;
    assign miss_evt = ((next_state == ALLOC) || (next_state == ALLOC2)) &&
                      (state != ALLOC) && (state != ALLOC2);
    assign wb_evt   = mem_wren && mem_ready && beat_last;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_evt && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
            if (miss_evt && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
            if (wb_evt && (wb_cnt != '1)) wb_cnt <= wb_cnt + 1'b1;
        end
    end
`endif

endmodule
